// File: rtl/rmw_array_pkg.sv
// Shared types and helpers for the streaming read-modify-write counter array.
// Default widths live here so the top and the array agree on sizing.
package rmw_array_pkg;

  localparam int IDX_W = 2;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] inc;
  } rmw_req_t;

  // Index of the last array entry for a given index width.
  function automatic int last_idx(input int w = IDX_W);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/rmw_array_mem.sv
// 2^W x CW array: one registered read port, one write port.
// A read at the same edge as a write to that entry returns the old value.
module rmw_array_mem
  import rmw_array_pkg::*;
#(
  parameter int W  = IDX_W,
  parameter int CW = CNT_W
) (
  input  logic          clock,
  input  logic [W-1:0]  rd_addr,
  output logic [CW-1:0] rd_data,
  input  logic          we,
  input  logic [W-1:0]  wr_addr,
  input  logic [CW-1:0] wr_data
);

  localparam int N = last_idx(W);

  logic [CW-1:0] mem [0:N];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rmw_counter_array.sv
// Streaming RMW accumulator: one op/cycle into a small array with forwarding,
// a clear sweep after drain, sticky threshold flag and saturating op counter.
module rmw_counter_array
  import rmw_array_pkg::*;
#(
  parameter int W      = IDX_W,
  parameter int CW     = CNT_W,
  parameter int THRESH = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_idx,
  input  logic [CW-1:0] in_inc,
  input  logic          in_clear,
  output logic          out_valid,
  output logic [W-1:0]  out_idx,
  output logic [CW-1:0] out_value,
  output logic          hit,
  output logic [63:0]   count
);

  localparam int N = last_idx(W);

  state_t        state, state_nx;
  logic [W-1:0]  ptr;
  logic [1:0]    vld_pipe;   // [0]: S1 holds an op, [1]: output pulse
  rmw_req_t      s1;
  logic          fwd_q;
  logic [CW-1:0] fwd_val, rd_data, s1_rd, s1_new;
  logic          accept;
  logic          we;
  logic [W-1:0]  wr_addr;
  logic [CW-1:0] wr_data;

  assign in_ready  = (state == RUN);
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[1];
  // Array read is stale when the previous op commits to the same entry.
  assign s1_rd     = fwd_q ? fwd_val : rd_data;
  assign s1_new    = s1_rd + s1.inc;

  assign we      = (state == CLEAR) | vld_pipe[0];
  assign wr_addr = (state == CLEAR) ? ptr : s1.idx;
  assign wr_data = (state == CLEAR) ? '0 : s1_new;

  rmw_array_mem #(.W(W), .CW(CW)) u_mem (
    .clock   (clock),
    .rd_addr (in_idx),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Nothing is accepted in DRAIN, so S1 is always empty after one edge there.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (in_clear) state_nx = DRAIN;
      DRAIN:   state_nx = CLEAR;
      CLEAR:   if (ptr == W'(N)) state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      ptr       <= '0;
      vld_pipe  <= '0;
      s1        <= '0;
      fwd_q     <= 1'b0;
      fwd_val   <= '0;
      out_idx   <= '0;
      out_value <= '0;
      hit       <= 1'b0;
      count     <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= (state == CLEAR) ? ptr + 1'b1 : '0;
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        s1      <= '{idx: in_idx, inc: in_inc};
        fwd_q   <= vld_pipe[0] && (s1.idx == in_idx);
        fwd_val <= s1_new;
      end
      if (vld_pipe[0]) begin
        out_idx   <= s1.idx;
        out_value <= s1_new;
      end
      // Entering CLEAR beats a same-edge threshold commit.
      if (state == DRAIN)
        hit <= 1'b0;
      else if (vld_pipe[0] && s1_new >= CW'(THRESH))
        hit <= 1'b1;
      if (accept && count != '1)
        count <= count + 64'd1;
    end
  end

endmodule

// File: tb/tb_rmw_counter_array.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// an in-order array model with a ready-blocking countdown.
module tb_rmw_counter_array;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_clear;
  logic [1:0]  in_idx;
  logic [6:0]  in_inc;
  logic        out_valid, hit;
  logic [1:0]  out_idx;
  logic [6:0]  out_value;
  logic [63:0] count;

  rmw_counter_array dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_inc    (in_inc),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_value (out_value),
    .hit       (hit),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       valid;
    logic [1:0] idx;
    logic [6:0] val;
    logic       hit;
    logic       clr;
  } exp_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [6:0]  ref_mem [4];
  logic        ref_hit;
  logic        hit_vis;
  logic [63:0] ref_cnt;
  int          blocked;
  exp_t        prev;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    ref_hit = 1'b0;
    hit_vis = 1'b0;
    ref_cnt = '0;
    blocked = 4;
    prev    = '{valid: 1'b0, idx: '0, val: '0, hit: 1'b0, clr: 1'b0};
  endtask

  // Called at a negedge: drive one cycle, advance the model, check the result.
  task automatic step(input logic v, input logic [1:0] idx, input logic [6:0] inc,
                      input logic clr);
    exp_t cur;
    logic acc;
    in_valid = v; in_idx = idx; in_inc = inc; in_clear = clr;
    #1;
    chk("in_ready", in_ready, blocked == 0);
    acc = v && (blocked == 0);
    cur = '{valid: 1'b0, idx: '0, val: '0, hit: 1'b0, clr: 1'b0};
    if (acc) begin
      cur.valid    = 1'b1;
      cur.idx      = idx;
      cur.val      = ref_mem[idx] + inc;
      ref_mem[idx] = cur.val;
      if (cur.val >= 7'd64) ref_hit = 1'b1;
      if (ref_cnt != '1) ref_cnt++;
    end
    if (clr && blocked == 0) begin
      cur.clr = 1'b1;
      ref_hit = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[i] = '0;
      blocked = 5;
    end else if (blocked > 0) begin
      blocked--;
    end
    cur.hit = ref_hit;
    @(posedge clock);
    @(negedge clock);
    chk("count", count, ref_cnt);
    chk("out_valid", out_valid, prev.valid);
    if (prev.valid) begin
      chk("out_idx", out_idx, prev.idx);
      chk("out_value", out_value, prev.val);
    end
    if (prev.clr) hit_vis = 1'b0;
    if (prev.valid) hit_vis = prev.hit;
    chk("hit", hit, hit_vis);
    prev = cur;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 7'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 7'd0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_idx = '0; in_inc = '0; in_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_hit", hit, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    reset_n = 1'b1;

    // Sweep after reset, then every entry reads back zero.
    idle(4);
    read_all();
    idle(1);
    chk("reset_reads_count", count, 4);

    // Back-to-back hazard on the same entry.
    step(1'b1, 2'd1, 7'd5, 1'b0);
    step(1'b1, 2'd1, 7'd3, 1'b0);
    chk("hazard_first", out_value, 5);
    idle(1);
    chk("hazard_second", out_value, 8);
    step(1'b1, 2'd1, 7'd0, 1'b0);
    idle(1);
    chk("hazard_mem1", out_value, 8);

    // Silent wrap: 10 x 13 = 130 -> 2, hit stays set.
    for (int i = 0; i < 10; i++) step(1'b1, 2'd2, 7'd13, 1'b0);
    idle(1);
    chk("wrap_value", out_value, 2);
    chk("wrap_hit", hit, 1);

    // Clear with a concurrent request.
    step(1'b1, 2'd0, 7'd7, 1'b1);
    idle(1);
    chk("clear_op_value", out_value, 7);
    idle(4);
    chk("clear_hit", hit, 0);
    read_all();
    idle(1);

    // Threshold boundary: 63 stays below, 64 sets hit.
    step(1'b1, 2'd3, 7'd63, 1'b0);
    idle(1);
    chk("thresh_below", hit, 0);
    step(1'b1, 2'd3, 7'd1, 1'b0);
    chk("thresh_pulse_valid", out_valid, 0);
    idle(1);
    chk("thresh_value", out_value, 64);
    chk("thresh_hit", hit, 1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
           7'($urandom_range(0, 127)), $urandom_range(0, 29) == 0);
    idle(6);

    // Reset while S1 holds an op: no output, counters restart.
    step(1'b1, 2'd2, 7'd9, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    chk("midrst_discard", out_valid, 0);
    reset_n = 1'b1;
    model_reset();
    idle(4);
    read_all();
    for (int i = 0; i < 40; i++)
      step(1'b1, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 40)), 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
